// File: rtl/multu_sequencer_pkg.sv
// Shared definitions for the sequential MULTU unit: operand width and FSM state encoding.
package multu_sequencer_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/multu_sequencer_adder.sv
// Fixed-width combinational adder shared with the ALU datapath.
// BitOverflow flags two's-complement overflow of the sum.
module multu_sequencer_adder
  import multu_sequencer_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] A,
  input  logic [MULT_WIDTH-1:0] B,
  output logic [MULT_WIDTH-1:0] Output,
  output logic                  BitOverflow
);

  assign Output      = A + B;
  assign BitOverflow = (A[MULT_WIDTH-1] == B[MULT_WIDTH-1]) &&
                       (Output[MULT_WIDTH-1] != A[MULT_WIDTH-1]);

endmodule

// File: rtl/multu_sequencer.sv
// Multi-cycle unsigned 32x32 multiplier: one shift-and-add step per clock through
// the shared adder, 64-bit product left in Hi/Lo.
module multu_sequencer
  import multu_sequencer_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             unused_ovf;

  assign bin = Lo[0] ? m : '0;

  multu_sequencer_adder u_adder (
    .A          (Hi),
    .B          (bin),
    .Output     (sum),
    .BitOverflow(unused_ovf)
  );

  // Unsigned carry-out recovered from the operand and sum MSBs.
  assign carry = (Hi[WIDTH-1] & bin[WIDTH-1]) |
                 ((Hi[WIDTH-1] | bin[WIDTH-1]) & ~sum[WIDTH-1]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
      count <= '0;
      m     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            m     <= OperandA;
            Lo    <= OperandB;
            Hi    <= '0;
            count <= '0;
            Busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          {Hi, Lo} <= {carry, sum, Lo[WIDTH-1:1]};
          count    <= count + 1'b1;
          if (count == LAST_ITER) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Self-checking bench for multu_sequencer: directed cases plus randomized operands
// compared every cycle against a cycle-count/product model.
module tb_multu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  multu_sequencer dut (
    .Clock   (clk),
    .Reset   (rst),
    .Start   (start),
    .OperandA(opa),
    .OperandB(opb),
    .Busy    (busy),
    .Done    (done),
    .Hi      (hi),
    .Lo      (lo)
  );

  always #5 clk = ~clk;

  // Model: an accepted request keeps the unit busy for 32 cycles, then the product
  // A*B is presented with a one-cycle done pulse and held until the next request.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;
  int          m_rem  = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_rem  = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
      if (m_rem == 0) m_prod = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_rem  = 32;
        m_busy = 1'b1;
        m_pend = 64'(opa) * 64'(opb);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      if (!m_busy) check("hilo", {hi, lo}, m_prod);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits (bounded) for its done pulse.
  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    output logic [63:0] res, output int lat);
    start = 1'b1;
    opa   = a;
    opb   = b;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    res = {hi, lo};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] res, res1, res2;
  int          lat, dlat, ndone, d1, d2;
  logic [31:0] ra, rb;

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    opa   = 32'd1;
    opb   = 32'd1;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    chk_en = 1'b1;
    rst    = 1'b0;
    start  = 1'b0;
    tick();

    op(32'd1, 32'd5, res, lat);
    check("t1_lat", 64'(lat), 64'd33);
    check("t1_res", res, 64'd5);
    tick();
    check("t1_pulse", 64'(done), 64'd0);

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("t2_lat", 64'(lat), 64'd33);
    check("t2_res", res, 64'hFFFF_FFFE_0000_0001);

    op(32'h8000_0000, 32'd2, res, lat);
    check("t3a_res", res, 64'h0000_0001_0000_0000);
    op(32'd0, 32'h1234, res, lat);
    check("t3b_lat", 64'(lat), 64'd33);
    check("t3b_res", res, 64'd0);

    // Second request mid-run must be dropped.
    start = 1'b1;
    opa   = 32'd7;
    opb   = 32'd6;
    tick();
    lat   = 1;
    ndone = 0;
    dlat  = 0;
    repeat (40) begin
      if (done) begin
        ndone++;
        if (dlat == 0) begin
          dlat = lat;
          res  = {hi, lo};
        end
      end
      start = (lat == 9);
      if (lat == 9) begin
        opa = 32'd3;
        opb = 32'd3;
      end
      tick();
      lat++;
    end
    check("t4_lat", 64'(dlat), 64'd33);
    check("t4_ndone", 64'(ndone), 64'd1);
    check("t4_res", res, 64'd42);

    // Start held through the done cycle chains a second operation.
    start = 1'b1;
    opa   = 32'd100;
    opb   = 32'd200;
    tick();
    lat = 1;
    d1  = 0;
    d2  = 0;
    repeat (80) begin
      if (done) begin
        if (d1 == 0) begin
          d1   = lat;
          res1 = {hi, lo};
          opa  = 32'hDEAD_BEEF;
          opb  = 32'h10;
        end else if (d2 == 0) begin
          d2   = lat;
          res2 = {hi, lo};
        end
      end
      if (d1 != 0 && lat > d1) start = 1'b0;
      tick();
      lat++;
    end
    check("t5_d1", 64'(d1), 64'd33);
    check("t5_res1", res1, 64'd20000);
    check("t5_d2", 64'(d2), 64'd66);
    check("t5_res2", res2, 64'h0000_000D_EADB_EEF0);

    // Reset in the middle of a run aborts it.
    start = 1'b1;
    opa   = 32'd5;
    opb   = 32'd7;
    tick();
    start = 1'b0;
    lat   = 1;
    while (lat < 14) begin
      tick();
      lat++;
    end
    rst = 1'b1;
    tick();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();
    op(32'd9, 32'd9, res, lat);
    check("t6_lat", 64'(lat), 64'd33);
    check("t6_res", res, 64'd81);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      op(ra, rb, res, lat);
      check("rnd_lat", 64'(lat), 64'd33);
      check("rnd_res", res, 64'(ra) * 64'(rb));
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
